// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - byte write strobe and first-word-fall-through read handshake
interface uart_rx_fifo_if #(
   parameter int WIDTH = 8
);
   logic             wr_stb;
   logic [WIDTH-1:0] wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output wr_stb, wr_data, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  wr_stb, wr_data, rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular receive FIFO behind the UART receiver, FWFT read side,
// registered occupancy flags and a sticky overflow flag.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   uart_rx_fifo_if.slave  io_bus,
   input  logic           i_ovf_clr,
   output logic [AW:0]    o_count,
   output logic           o_empty,
   output logic           o_full,
   output logic           o_overflow
);
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [WIDTH-1:0] r_mem [2**AW];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_empty;
   logic             r_full;
   logic             r_ovf;

   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [AW:0]      w_count_nxt;

   assign w_pop  = !r_empty && io_bus.rd_ready;
   assign w_push = io_bus.wr_stb && (!r_full || w_pop);
   assign w_drop = io_bus.wr_stb && r_full && !w_pop;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + (AW+1)'(1);
      else if (w_pop && !w_push)
         w_count_nxt = r_count - (AW+1)'(1);
   end

   // Storage is deliberately left out of reset; only the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_push)
         r_mem[r_wr_ptr] <= io_bus.wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == DEPTH);
         // A dropped write in the same cycle as a clear keeps the flag set.
         if (w_drop)
            r_ovf <= 1'b1;
         else if (i_ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   assign io_bus.rd_valid = !r_empty;
   assign io_bus.rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count         = r_count;
   assign o_empty         = r_empty;
   assign o_full          = r_full;
   assign o_overflow      = r_ovf;
endmodule
